// File: rtl/rst_seq_ctrl_if.sv
// Reset-sequencer bus: hold-off inputs, software re-reset handshake and the
// per-domain reset outputs. The slave modport is the sequencer itself; the
// master modport is whatever drives HOLD / SW_RST_REQ and consumes the resets.
interface rst_seq_ctrl_if #(
    parameter int NUM_DOM = 4
);
    logic [NUM_DOM-1:0] HOLD;
    logic               SW_RST_REQ;
    logic               SW_RST_ACK;
    logic [NUM_DOM-1:0] DOM_RSTB;
    logic               SEQ_BUSY;
    logic               SEQ_DONE;

    modport master (
        output HOLD,
        output SW_RST_REQ,
        input  SW_RST_ACK,
        input  DOM_RSTB,
        input  SEQ_BUSY,
        input  SEQ_DONE
    );

    modport slave (
        input  HOLD,
        input  SW_RST_REQ,
        output SW_RST_ACK,
        output DOM_RSTB,
        output SEQ_BUSY,
        output SEQ_DONE
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronizes chip-reset deassertion, then releases the
// per-domain active-low resets in index order with a fixed gap, honouring a
// per-domain hold-off for whichever domain is next. Once all domains are out
// of reset, a 4-phase REQ/ACK handshake lets software re-run the sequence.
module rst_seq_ctrl #(
    parameter int NUM_DOM     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 8,
    parameter int CNT_W       = $clog2(GAP_CYCLES + 1)
) (
    input  logic         CLK,
    input  logic         RSTB,
    rst_seq_ctrl_if.slave bus
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOM - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_SYNC,
        S_RELEASE,
        S_GAP,
        S_DONE,
        S_SW_ASSERT,
        S_SW_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_DOM-1:0]     r_dom_rstb;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ack;

    logic                   w_sync_ok;
    logic                   w_try;
    logic [IDX_W-1:0]       w_try_idx;
    logic                   w_hold_hit;

    // Deassert synchronizer: a 1 ripples in, any RSTB low clears every stage.
    // NOTE: state registers use non-blocking assignments so all flops sample
    // pre-edge values together, independent of process ordering.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_sync_ok = r_sync[SYNC_STAGES-1];

    // Decide whether this edge attempts a release, and of which domain. The
    // sync-done edge and the gap-expiry edge release directly so the first
    // domain and every later one come out on the intended edge.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_try     = 1'b0;
        w_try_idx = r_idx;
        case (r_state)
            S_WAIT_SYNC: begin
                w_try     = w_sync_ok;
                w_try_idx = '0;
            end
            S_RELEASE: w_try = 1'b1;
            S_GAP: begin
                w_try     = (r_cnt == '0);
                w_try_idx = r_idx + IDX_W'(1);
            end
            default: ;
        endcase
    end

    assign w_hold_hit = bus.HOLD[w_try_idx];

    // Sequencing FSM with all outputs registered.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state    <= S_WAIT_SYNC;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_dom_rstb <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_ack      <= 1'b0;
        end else if (w_try) begin
            if (!w_hold_hit) begin
                r_dom_rstb[w_try_idx] <= 1'b1;
                if (w_try_idx == LAST_IDX) begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end else begin
                    r_cnt   <= CNT_LOAD;
                    r_idx   <= w_try_idx;
                    r_state <= S_GAP;
                end
            end else begin
                // Stalled by hold-off: park on this domain, counter untouched.
                r_idx   <= w_try_idx;
                r_state <= S_RELEASE;
            end
        end else begin
            case (r_state)
                S_GAP: r_cnt <= r_cnt - CNT_W'(1);
                S_DONE: begin
                    if (bus.SW_RST_REQ) begin
                        r_dom_rstb <= '0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_cnt      <= CNT_LOAD;
                        r_state    <= S_SW_ASSERT;
                    end
                end
                S_SW_ASSERT: begin
                    if (r_cnt == '0) begin
                        r_ack   <= 1'b1;
                        r_state <= S_SW_WAIT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_SW_WAIT: begin
                    if (!bus.SW_RST_REQ) begin
                        r_ack   <= 1'b0;
                        r_idx   <= '0;
                        r_state <= S_RELEASE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.DOM_RSTB   = r_dom_rstb;
    assign bus.SEQ_BUSY   = r_busy;
    assign bus.SEQ_DONE   = r_done;
    assign bus.SW_RST_ACK = r_ack;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: a default instance (4 domains, gap 8, 2 sync
// stages) and a minimal one (1 domain, gap 1, 3 sync stages) share clock and
// chip reset. A timestamp model predicts every output each cycle; directed
// phases pin the documented edge numbers, then a random phase follows.
module tb_rst_seq_ctrl;

    logic CLK;
    logic RSTB;

    rst_seq_ctrl_if #(.NUM_DOM(4)) bus_a ();
    rst_seq_ctrl_if #(.NUM_DOM(1)) bus_b ();

    rst_seq_ctrl #(.NUM_DOM(4), .SYNC_STAGES(2), .GAP_CYCLES(8)) dut_a (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (bus_a)
    );

    rst_seq_ctrl #(.NUM_DOM(1), .SYNC_STAGES(3), .GAP_CYCLES(1)) dut_b (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (bus_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int ecnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: edges seen since RSTB rose, next domain to release, the
    // earliest edge it may be released on, and the handshake phase.
    localparam int M_SEQ = 0, M_DONE = 1, M_ASSERT = 2, M_WAIT = 3;
    int P_N[2]    = '{4, 1};
    int P_GAP[2]  = '{8, 1};
    int P_SYNC[2] = '{2, 3};

    int         m_n[2];
    int         m_next[2];
    int         m_elig[2];
    int         m_mode[2];
    int         m_ack_at[2];
    logic [3:0] m_dom[2];
    logic       m_done[2];
    logic       m_busy[2];
    logic       m_ack[2];

    task automatic model_reset(input int i);
        m_n[i]    = 0;
        m_next[i] = 0;
        m_elig[i] = P_SYNC[i] + 1;
        m_mode[i] = M_SEQ;
        m_dom[i]  = 4'b0000;
        m_done[i] = 1'b0;
        m_busy[i] = 1'b1;
        m_ack[i]  = 1'b0;
    endtask

    task automatic model_step(input int i, input logic [3:0] hold, input logic req);
        m_n[i] = m_n[i] + 1;
        case (m_mode[i])
            M_SEQ: begin
                if (m_n[i] >= m_elig[i] && !hold[m_next[i]]) begin
                    m_dom[i][m_next[i]] = 1'b1;
                    if (m_next[i] == P_N[i] - 1) begin
                        m_mode[i] = M_DONE;
                        m_done[i] = 1'b1;
                        m_busy[i] = 1'b0;
                    end else begin
                        m_elig[i] = m_n[i] + P_GAP[i];
                        m_next[i] = m_next[i] + 1;
                    end
                end
            end
            M_DONE: begin
                if (req) begin
                    m_dom[i]    = 4'b0000;
                    m_done[i]   = 1'b0;
                    m_busy[i]   = 1'b1;
                    m_ack_at[i] = m_n[i] + P_GAP[i];
                    m_mode[i]   = M_ASSERT;
                end
            end
            M_ASSERT: begin
                if (m_n[i] == m_ack_at[i]) begin
                    m_ack[i]  = 1'b1;
                    m_mode[i] = M_WAIT;
                end
            end
            default: begin
                if (!req) begin
                    m_ack[i]  = 1'b0;
                    m_mode[i] = M_SEQ;
                    m_next[i] = 0;
                    m_elig[i] = m_n[i] + 1;
                end
            end
        endcase
    endtask

    always @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, bus_a.HOLD, bus_a.SW_RST_REQ);
            model_step(1, {3'b000, bus_b.HOLD}, bus_b.SW_RST_REQ);
        end
    end

    // Edge counter for the directed phases: edges since RSTB last rose.
    always @(posedge CLK or negedge RSTB) begin
        if (!RSTB) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    // Cycle-by-cycle compare against the model, away from the active edge.
    always @(negedge CLK) begin
        check("a_dom",  32'(bus_a.DOM_RSTB),   32'(m_dom[0]));
        check("a_busy", 32'(bus_a.SEQ_BUSY),   32'(m_busy[0]));
        check("a_done", 32'(bus_a.SEQ_DONE),   32'(m_done[0]));
        check("a_ack",  32'(bus_a.SW_RST_ACK), 32'(m_ack[0]));
        check("b_dom",  32'(bus_b.DOM_RSTB),   32'(m_dom[1][0]));
        check("b_busy", 32'(bus_b.SEQ_BUSY),   32'(m_busy[1]));
        check("b_done", 32'(bus_b.SEQ_DONE),   32'(m_done[1]));
        check("b_ack",  32'(bus_b.SW_RST_ACK), 32'(m_ack[1]));
    end

    // ---------------- directed helpers ----------------
    task automatic wait_edge(input int k);
        int guard = 0;
        while (ecnt < k && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        check("wait_edge", 32'(ecnt), 32'(k));
    endtask

    // Short low pulse on RSTB between edges; outputs must clear with no clock.
    task automatic pulse_rstb();
        @(posedge CLK);
        #2 RSTB = 1'b0;
        #1;
        check("rst_imm_a_dom",  32'(bus_a.DOM_RSTB), 32'h0);
        check("rst_imm_a_busy", 32'(bus_a.SEQ_BUSY), 32'h1);
        check("rst_imm_a_ack",  32'(bus_a.SW_RST_ACK), 32'h0);
        check("rst_imm_b_dom",  32'(bus_b.DOM_RSTB), 32'h0);
        @(negedge CLK);
        RSTB = 1'b1;
    endtask

    task automatic check_default_timing();
        wait_edge(2);  check("t2_dom",  32'(bus_a.DOM_RSTB), 32'h0);
        wait_edge(3);  check("t3_dom",  32'(bus_a.DOM_RSTB), 32'h1);
                       check("t3_model", 32'(m_dom[0]), 32'h1);
        wait_edge(4);  check("b_t4_dom",  32'(bus_b.DOM_RSTB), 32'h1);
                       check("b_t4_done", 32'(bus_b.SEQ_DONE), 32'h1);
        wait_edge(10); check("t10_dom", 32'(bus_a.DOM_RSTB), 32'h1);
        wait_edge(11); check("t11_dom", 32'(bus_a.DOM_RSTB), 32'h3);
        wait_edge(19); check("t19_dom", 32'(bus_a.DOM_RSTB), 32'h7);
        wait_edge(26); check("t26_done", 32'(bus_a.SEQ_DONE), 32'h0);
        wait_edge(27); check("t27_dom",  32'(bus_a.DOM_RSTB), 32'hF);
                       check("t27_done", 32'(bus_a.SEQ_DONE), 32'h1);
                       check("t27_busy", 32'(bus_a.SEQ_BUSY), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e;
        RSTB = 1'b0;
        bus_a.HOLD = '0;
        bus_a.SW_RST_REQ = 1'b0;
        bus_b.HOLD = '0;
        bus_b.SW_RST_REQ = 1'b0;
        model_reset(0);
        model_reset(1);

        repeat (3) @(negedge CLK);
        check("rst_dom",  32'(bus_a.DOM_RSTB),   32'h0);
        check("rst_busy", 32'(bus_a.SEQ_BUSY),   32'h1);
        check("rst_done", 32'(bus_a.SEQ_DONE),   32'h0);
        check("rst_ack",  32'(bus_a.SW_RST_ACK), 32'h0);
        RSTB = 1'b1;

        // Default release timing, then HOLD[0] after DONE does nothing.
        check_default_timing();
        bus_a.HOLD = 4'b0001;
        repeat (5) @(negedge CLK);
        check("hold_after_done", 32'(bus_a.DOM_RSTB), 32'hF);
        bus_a.HOLD = 4'b0000;

        // Software re-reset on both instances.
        e = ecnt + 1;
        bus_a.SW_RST_REQ = 1'b1;
        bus_b.SW_RST_REQ = 1'b1;
        wait_edge(e);     check("sw_dom0",  32'(bus_a.DOM_RSTB), 32'h0);
                          check("sw_done0", 32'(bus_a.SEQ_DONE), 32'h0);
                          check("sw_b_dom", 32'(bus_b.DOM_RSTB), 32'h0);
        wait_edge(e + 1); check("sw_b_ack", 32'(bus_b.SW_RST_ACK), 32'h1);
        wait_edge(e + 7); check("sw_ack_early", 32'(bus_a.SW_RST_ACK), 32'h0);
        wait_edge(e + 8); check("sw_ack", 32'(bus_a.SW_RST_ACK), 32'h1);
        bus_a.SW_RST_REQ = 1'b0;
        bus_b.SW_RST_REQ = 1'b0;
        wait_edge(e + 9);  check("sw_ack_drop", 32'(bus_a.SW_RST_ACK), 32'h0);
                           check("sw_still_rst", 32'(bus_a.DOM_RSTB), 32'h0);
        wait_edge(e + 10); check("sw_rel0", 32'(bus_a.DOM_RSTB), 32'h1);
                           check("sw_b_rel", 32'(bus_b.DOM_RSTB), 32'h1);
        wait_edge(e + 34); check("sw_rel3", 32'(bus_a.DOM_RSTB), 32'hF);

        // Chip reset pulse while done, then again mid-gap; timing repeats.
        pulse_rstb();
        wait_edge(15); check("gap15_dom", 32'(bus_a.DOM_RSTB), 32'h3);
        pulse_rstb();
        check_default_timing();

        // HOLD[2] stalls domain 2 until edge 30; REQ held all along.
        bus_a.HOLD = 4'b0100;
        bus_a.SW_RST_REQ = 1'b1;
        pulse_rstb();
        wait_edge(19); check("h19_dom", 32'(bus_a.DOM_RSTB), 32'h3);
        wait_edge(27); check("h27_dom", 32'(bus_a.DOM_RSTB), 32'h3);
                       check("h27_busy", 32'(bus_a.SEQ_BUSY), 32'h1);
        wait_edge(30); check("h30_dom", 32'(bus_a.DOM_RSTB), 32'h3);
        bus_a.HOLD = 4'b0000;
        wait_edge(31); check("h31_dom", 32'(bus_a.DOM_RSTB), 32'h7);
        wait_edge(38); check("h38_dom", 32'(bus_a.DOM_RSTB), 32'h7);
        wait_edge(39); check("h39_dom", 32'(bus_a.DOM_RSTB), 32'hF);
                       check("h39_done", 32'(bus_a.SEQ_DONE), 32'h1);
        wait_edge(40); check("h40_dom", 32'(bus_a.DOM_RSTB), 32'h0);
                       check("h40_busy", 32'(bus_a.SEQ_BUSY), 32'h1);
        wait_edge(48); check("h48_ack", 32'(bus_a.SW_RST_ACK), 32'h1);
        bus_a.SW_RST_REQ = 1'b0;

        // Random phase: sparse hold-offs, request toggles, reset glitches.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            for (int d = 0; d < 4; d++)
                bus_a.HOLD[d] = ($urandom_range(0, 7) == 0);
            bus_b.HOLD = 1'($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) bus_a.SW_RST_REQ = ~bus_a.SW_RST_REQ;
            if ($urandom_range(0, 15) == 0) bus_b.SW_RST_REQ = ~bus_b.SW_RST_REQ;
            if ($urandom_range(0, 199) == 0) pulse_rstb();
        end

        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
